// File: rtl/stack_op_unit.sv
// Stack operation sequencer: PUSH/POP/CALL/RET with a single memory access and
// a one-cycle ESP commit strobe. Moore outputs decoded from state and latched operands.
module stack_op_unit #(
    parameter int DATA_W     = 32,
    parameter int STACK_STEP = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic [1:0]        op_code,
    input  logic [DATA_W-1:0] op_data,
    input  logic [DATA_W-1:0] ret_addr,
    input  logic [DATA_W-1:0] esp,
    output logic [DATA_W-1:0] alu_result_bus,
    output logic [3:0]        read_or_write,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              pop_valid,
    output logic [DATA_W-1:0] pop_data,
    output logic              eip_load,
    output logic [DATA_W-1:0] eip_target,
    output logic              stack_fault
);
    localparam logic [1:0] OP_PUSH = 2'b00;
    localparam logic [1:0] OP_POP  = 2'b01;
    localparam logic [1:0] OP_CALL = 2'b10;
    localparam logic [1:0] OP_RET  = 2'b11;

    localparam logic [DATA_W-1:0] STEP      = DATA_W'(STACK_STEP);
    localparam logic [DATA_W-1:0] POP_LIMIT = DATA_W'(0) - STEP;

    typedef enum logic [1:0] {S_IDLE, S_MEM, S_COMMIT} state_t;

    state_t            state_reg, state_next;
    logic [1:0]        op_code_reg;
    logic [DATA_W-1:0] op_data_reg;
    logic [DATA_W-1:0] ret_addr_reg;
    logic [DATA_W-1:0] esp_reg;
    logic [DATA_W-1:0] rdata_reg;
    logic              fault_reg;

    logic accept;
    logic fault_hit;
    logic fault_now;
    logic is_write_op;

    // Bit 0 of the opcode separates write-type (PUSH/CALL) from read-type (POP/RET).
    assign is_write_op = ~op_code_reg[0];

    assign fault_now = (esp[1:0] != 2'b00)
                    || (~op_code[0] && (esp < STEP))
                    || ( op_code[0] && (esp > POP_LIMIT));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg    <= S_IDLE;
            op_code_reg  <= 2'b00;
            op_data_reg  <= '0;
            ret_addr_reg <= '0;
            esp_reg      <= '0;
            rdata_reg    <= '0;
            fault_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                op_code_reg  <= op_code;
                op_data_reg  <= op_data;
                ret_addr_reg <= ret_addr;
                esp_reg      <= esp;
            end
            if (state_reg == S_MEM && mem_ack) begin
                rdata_reg <= mem_rdata;
            end
            if (fault_hit) begin
                fault_reg <= 1'b1;
            end
        end
    end

    always_comb begin
        state_next     = state_reg;
        accept         = 1'b0;
        fault_hit      = 1'b0;
        op_ready       = 1'b0;
        mem_addr       = '0;
        mem_wdata      = '0;
        mem_we         = 1'b0;
        mem_re         = 1'b0;
        alu_result_bus = '0;
        read_or_write  = 4'h0;
        pop_valid      = 1'b0;
        pop_data       = '0;
        eip_load       = 1'b0;
        eip_target     = '0;
        case (state_reg)
            S_IDLE: begin
                op_ready = 1'b1;
                if (op_valid) begin
                    accept = 1'b1;
                    if (fault_now) begin
                        fault_hit = 1'b1;
                    end else begin
                        state_next = S_MEM;
                    end
                end
            end
            S_MEM: begin
                mem_we = is_write_op;
                mem_re = ~is_write_op;
                if (is_write_op) begin
                    mem_addr  = esp_reg - STEP;
                    mem_wdata = (op_code_reg == OP_CALL) ? ret_addr_reg : op_data_reg;
                end else begin
                    mem_addr = esp_reg;
                end
                if (mem_ack) begin
                    state_next = S_COMMIT;
                end
            end
            S_COMMIT: begin
                state_next     = S_IDLE;
                read_or_write  = 4'h1;
                alu_result_bus = is_write_op ? (esp_reg - STEP) : (esp_reg + STEP);
                if (op_code_reg == OP_POP) begin
                    pop_valid = 1'b1;
                    pop_data  = rdata_reg;
                end
                if (op_code_reg == OP_CALL) begin
                    eip_load   = 1'b1;
                    eip_target = op_data_reg;
                end
                if (op_code_reg == OP_RET) begin
                    eip_load   = 1'b1;
                    eip_target = rdata_reg;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign stack_fault = fault_reg;

    // OP_PUSH is implied by the bit-0 decode; referenced here so the encoding stays documented.
    logic unused_push;
    assign unused_push = (op_code_reg == OP_PUSH);

endmodule

// File: tb/tb_stack_op_unit.sv
// Self-checking bench for stack_op_unit: directed cases, faults, async reset mid-op,
// and randomized op streams against a memory/ESP reference model.
module tb_stack_op_unit;
    localparam logic [1:0] OP_PUSH = 2'b00;
    localparam logic [1:0] OP_POP  = 2'b01;
    localparam logic [1:0] OP_CALL = 2'b10;
    localparam logic [1:0] OP_RET  = 2'b11;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        op_valid = 1'b0;
    logic        op_ready;
    logic [1:0]  op_code = 2'b00;
    logic [31:0] op_data = '0;
    logic [31:0] ret_addr = '0;
    logic [31:0] esp = '0;
    logic [31:0] alu_result_bus;
    logic [3:0]  read_or_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic        mem_re;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        pop_valid;
    logic [31:0] pop_data;
    logic        eip_load;
    logic [31:0] eip_target;
    logic        stack_fault;

    int checks = 0;
    int errors = 0;
    logic [31:0] mem_model [logic [31:0]];

    stack_op_unit #(.DATA_W(32), .STACK_STEP(4)) dut (
        .clock(clock), .reset(reset),
        .op_valid(op_valid), .op_ready(op_ready), .op_code(op_code),
        .op_data(op_data), .ret_addr(ret_addr), .esp(esp),
        .alu_result_bus(alu_result_bus), .read_or_write(read_or_write),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .pop_valid(pop_valid), .pop_data(pop_data),
        .eip_load(eip_load), .eip_target(eip_target), .stack_fault(stack_fault)
    );

    always #5 clock = ~clock;

    // Runs one op through accept, MEM (with 'delay' wait cycles), COMMIT and back to IDLE.
    task automatic do_op(input logic [1:0] code, input logic [31:0] data, input logic [31:0] ra,
                         input logic [31:0] sp, input int delay, output logic [31:0] new_sp);
        logic        wr;
        logic [31:0] addr, wdata, rv, exp_target;
        logic [104:0] obs, exp;
        wr     = (code == OP_PUSH) || (code == OP_CALL);
        addr   = wr ? sp - 32'd4 : sp;
        wdata  = (code == OP_PUSH) ? data : (code == OP_CALL) ? ra : 32'h0;
        new_sp = wr ? sp - 32'd4 : sp + 32'd4;
        if (wr) begin
            rv = $urandom;
            mem_model[addr] = wdata;
        end else begin
            if (!mem_model.exists(addr)) mem_model[addr] = $urandom;
            rv = mem_model[addr];
        end
        exp_target = (code == OP_CALL) ? data : (code == OP_RET) ? rv : 32'h0;

        @(negedge clock);
        checks++;
        if (op_ready !== 1'b1) begin
            errors++;
            $display("FAIL accept_ready op=%0d got=%b want=1", code, op_ready);
        end
        op_valid = 1'b1; op_code = code; op_data = data; ret_addr = ra; esp = sp;
        @(negedge clock);
        op_valid = 1'b0;
        for (int k = 0; k <= delay; k++) begin
            obs = {op_ready, mem_we, mem_re, mem_addr, mem_wdata, read_or_write,
                   alu_result_bus, pop_valid, eip_load};
            exp = {1'b0, wr, !wr, addr, wdata, 4'h0, 32'h0, 1'b0, 1'b0};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL mem_phase op=%0d cyc=%0d got=%h want=%h", code, k, obs, exp);
            end
            esp = $urandom;
            if (k == delay) begin
                mem_ack = 1'b1; mem_rdata = rv;
            end else begin
                mem_rdata = $urandom;
            end
            @(negedge clock);
        end
        mem_ack = 1'b0; mem_rdata = $urandom;
        obs = {op_ready, mem_we, mem_re, read_or_write, alu_result_bus,
               pop_valid, pop_data, eip_load, eip_target};
        exp = {1'b0, 1'b0, 1'b0, 4'h1, new_sp, (code == OP_POP),
               (code == OP_POP) ? rv : 32'h0, code[1], exp_target};
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL commit op=%0d got=%h want=%h", code, obs, exp);
        end
        @(negedge clock);
        obs = {op_ready, mem_we, mem_re, read_or_write, alu_result_bus,
               pop_valid, pop_data, eip_load, eip_target};
        exp = {1'b1, 2'b00, 4'h0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0};
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL back_to_idle op=%0d got=%h want=%h", code, obs, exp);
        end
        $display("op=%0d esp=%h addr=%h new_esp=%h delay=%0d", code, sp, addr, new_sp, delay);
    endtask

    task automatic fault_op(input logic [1:0] code, input logic [31:0] sp);
        logic [7:0] obs;
        @(negedge clock);
        op_valid = 1'b1; op_code = code; op_data = $urandom; ret_addr = $urandom; esp = sp;
        mem_ack = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clock);
            op_valid = 1'b0; mem_ack = 1'b0;
            obs = {op_ready, mem_we, mem_re, read_or_write, stack_fault};
            checks++;
            if (obs !== 8'b1_0_0_0000_1) begin
                errors++;
                $display("FAIL fault op=%0d esp=%h cyc=%0d got=%b want=10000001", code, sp, k, obs);
            end
        end
        $display("fault op=%0d esp=%h", code, sp);
    endtask

    task automatic test_reset();
        logic [104:0] obs;
        reset = 1'b0;
        #2;
        obs = {op_ready, mem_we, mem_re, mem_addr, mem_wdata, read_or_write, alu_result_bus,
               pop_valid, eip_load};
        checks++;
        if (obs !== {1'b1, 104'h0}) begin
            errors++;
            $display("FAIL reset_outputs got=%h want=%h", obs, {1'b1, 104'h0});
        end
        checks++;
        if (stack_fault !== 1'b0) begin
            errors++;
            $display("FAIL reset_fault got=%b want=0", stack_fault);
        end
        @(negedge clock);
        reset = 1'b1;
        $display("reset released");
    endtask

    task automatic test_directed();
        logic [31:0] ns;
        do_op(OP_PUSH, 32'hDEADBEEF, 32'h0, 32'h00001000, 2, ns);
        mem_model[32'h00000FFC] = 32'h12345678;
        do_op(OP_POP, 32'h0, 32'h0, 32'h00000FFC, 0, ns);
        do_op(OP_CALL, 32'h00000400, 32'h00000104, 32'h00002000, 1, ns);
        checks++;
        if (mem_model[32'h00001FFC] !== 32'h00000104) begin
            errors++;
            $display("FAIL call_model got=%h want=00000104", mem_model[32'h00001FFC]);
        end
        do_op(OP_RET, 32'h0, 32'h0, 32'h00001FFC, 0, ns);
    endtask

    task automatic test_boundaries();
        logic [31:0] ns;
        do_op(OP_PUSH, 32'hA5A5A5A5, 32'h0, 32'h00000004, 0, ns);
        do_op(OP_POP, 32'h0, 32'h0, 32'hFFFFFFFC, 1, ns);
    endtask

    task automatic test_faults();
        logic [31:0] ns;
        fault_op(OP_PUSH, 32'h00000002);
        fault_op(OP_POP, 32'hFFFFFFFE);
        fault_op(OP_CALL, 32'h00000000);
        fault_op(OP_RET, 32'h00001003);
        do_op(OP_PUSH, 32'h0BADF00D, 32'h0, 32'h00003000, 1, ns);
        checks++;
        if (stack_fault !== 1'b1) begin
            errors++;
            $display("FAIL fault_sticky got=%b want=1", stack_fault);
        end
    endtask

    task automatic test_random();
        logic [31:0] sp, ns;
        logic [1:0]  code;
        sp = 32'h00008000;
        for (int i = 0; i < 40; i++) begin
            code = 2'($urandom_range(0, 3));
            do_op(code, $urandom, $urandom, sp, $urandom_range(0, 3), ns);
            sp = ns;
        end
    endtask

    task automatic test_reset_mid_op();
        logic [104:0] obs;
        @(negedge clock);
        op_valid = 1'b1; op_code = OP_PUSH; op_data = 32'h55AA55AA; esp = 32'h00004000;
        @(negedge clock);
        op_valid = 1'b0;
        checks++;
        if ({mem_we, mem_addr} !== {1'b1, 32'h00003FFC}) begin
            errors++;
            $display("FAIL reset_pre_mem got=%h want=%h", {mem_we, mem_addr}, {1'b1, 32'h00003FFC});
        end
        #2 reset = 1'b0;
        #1;
        obs = {op_ready, mem_we, mem_re, mem_addr, mem_wdata, read_or_write, alu_result_bus,
               pop_valid, eip_load};
        checks++;
        if (obs !== {1'b1, 104'h0}) begin
            errors++;
            $display("FAIL reset_async got=%h want=%h", obs, {1'b1, 104'h0});
        end
        mem_ack = 1'b1;
        @(negedge clock);
        reset = 1'b1; mem_ack = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            checks++;
            if ({op_ready, stack_fault, read_or_write} !== 6'b10_0000) begin
                errors++;
                $display("FAIL reset_after cyc=%0d got=%b want=100000", k,
                         {op_ready, stack_fault, read_or_write});
            end
        end
        $display("reset mid-op done");
    endtask

    initial begin
        test_reset();
        test_directed();
        test_boundaries();
        test_faults();
        test_random();
        test_reset_mid_op();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
